// File: rtl/maze_constraint_loader.sv
// maze_constraint_loader: streams one level's tiles from a ROM into four per-cell wall bitmaps.
// Define WALL_SYMMETRY_EN to also mirror each wall into the facing bit of the in-bounds neighbour.
module maze_constraint_loader #(
    parameter int size_y = 20,
    parameter int size_x = 40
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [1:0]        level,
    output logic [11:0]       tile_addr,
    input  logic [3:0]        tile_data,
    output logic [0:size_x-1] up_constraint    [size_y-1:0],
    output logic [0:size_x-1] down_constraint  [size_y-1:0],
    output logic [0:size_x-1] left_constraint  [size_y-1:0],
    output logic [0:size_x-1] right_constraint [size_y-1:0],
    output logic              busy,
    output logic              game_ready
);
    localparam int XW = $clog2(size_x);
    localparam int YW = $clog2(size_y);
    localparam logic [11:0]   CELLS = 12'(size_x * size_y);
    localparam logic [11:0]   ROW   = 12'(size_x);
    localparam logic [XW-1:0] X_MAX = XW'(size_x - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(size_y - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t        r_state;
    logic [1:0]    r_level;
    logic [XW-1:0] r_x, r_dx;
    logic [YW-1:0] r_y, r_dy;
    logic          r_dv;
    logic          w_up, w_dn, w_lf, w_rt;

    assign tile_addr = (r_state == FETCH) ? 12'(r_level) * CELLS + 12'(r_y) * ROW + 12'(r_x) : '0;

    // Walls of the cell whose ROM data arrives this cycle, with the outer border forced on.
    assign w_up = tile_data[3] | (r_dy == '0);
    assign w_dn = tile_data[2] | (r_dy == Y_MAX);
    assign w_lf = tile_data[1] | (r_dx == '0);
    assign w_rt = tile_data[0] | (r_dx == X_MAX);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_level    <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_dv       <= 1'b0;
            busy       <= 1'b0;
            game_ready <= 1'b0;
            for (int i = 0; i < size_y; i++) begin
                up_constraint[i]    <= '0;
                down_constraint[i]  <= '0;
                left_constraint[i]  <= '0;
                right_constraint[i] <= '0;
            end
        end else begin
            r_dv <= (r_state == FETCH);
            if ((r_state == IDLE || r_state == DONE) && start) begin
                r_state    <= FETCH;
                r_level    <= level;
                r_x        <= '0;
                r_y        <= '0;
                busy       <= 1'b1;
                game_ready <= 1'b0;
                for (int i = 0; i < size_y; i++) begin
                    up_constraint[i]    <= '0;
                    down_constraint[i]  <= '0;
                    left_constraint[i]  <= '0;
                    right_constraint[i] <= '0;
                end
            end else if (r_state == FETCH) begin
                r_dx <= r_x;
                r_dy <= r_y;
                if (r_x == X_MAX) begin
                    r_x <= '0;
                    if (r_y == Y_MAX)
                        r_state <= DRAIN;
                    else
                        r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end else if (r_state == DRAIN) begin
                r_state    <= DONE;
                busy       <= 1'b0;
                game_ready <= 1'b1;
            end
            // OR rather than assign: a mirrored wall may already sit in a cell not yet fetched.
            if (r_dv) begin
                up_constraint[r_dy][r_dx]    <= up_constraint[r_dy][r_dx] | w_up;
                down_constraint[r_dy][r_dx]  <= down_constraint[r_dy][r_dx] | w_dn;
                left_constraint[r_dy][r_dx]  <= left_constraint[r_dy][r_dx] | w_lf;
                right_constraint[r_dy][r_dx] <= right_constraint[r_dy][r_dx] | w_rt;
`ifdef WALL_SYMMETRY_EN
                if (r_dx != X_MAX)
                    left_constraint[r_dy][r_dx + 1'b1] <= left_constraint[r_dy][r_dx + 1'b1] | w_rt;
                if (r_dx != '0)
                    right_constraint[r_dy][r_dx - 1'b1] <= right_constraint[r_dy][r_dx - 1'b1] | w_lf;
                if (r_dy != Y_MAX)
                    up_constraint[r_dy + 1'b1][r_dx] <= up_constraint[r_dy + 1'b1][r_dx] | w_dn;
                if (r_dy != '0)
                    down_constraint[r_dy - 1'b1][r_dx] <= down_constraint[r_dy - 1'b1][r_dx] | w_up;
`endif
            end
        end
    end
endmodule
